// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage and its prefetch queue.
// The {pc, word} entry struct is declared at each use site because its pc width follows addWidth.
package instr_fetch_pkg;

  localparam int INSTR_W          = 32;
  localparam int DEFAULT_RESET_PC = 0;

endpackage

// File: rtl/instr_queue.sv
// Prefetch FIFO of {pc, word} entries with flush, a per-entry pc match vector
// for store snooping, and the pc of the oldest entry that survives this cycle's pop.
module instr_queue
  import instr_fetch_pkg::*;
#(
  parameter int addWidth = 8,
  parameter int DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  logic                    i_flush,
  input  logic [addWidth-1:0]     i_pushPc,
  input  logic [INSTR_W-1:0]      i_pushWord,
  input  logic [addWidth-1:0]     i_snoopAddr,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic [addWidth-1:0]     o_headPc,
  output logic [INSTR_W-1:0]      o_headWord,
  output logic [DEPTH-1:0]        o_matchVec,
  output logic [addWidth-1:0]     o_survivorPc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [addWidth-1:0] pc;
    logic [INSTR_W-1:0]  word;
  } entry_t;

  entry_t               r_entries [DEPTH];
  logic [PTR_W-1:0]     r_head;
  logic [PTR_W-1:0]     r_tail;
  logic [CNT_W-1:0]     r_count;
  logic [PTR_W-1:0]     w_rel [DEPTH];
  logic [PTR_W-1:0]     w_nextHead;

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + PTR_W'(1);
      if (i_pop)  r_head <= r_head + PTR_W'(1);
      if (i_push && !i_pop)      r_count <= r_count + CNT_W'(1);
      else if (i_pop && !i_push) r_count <= r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_entries[r_tail].pc   <= i_pushPc;
      r_entries[r_tail].word <= i_pushWord;
    end
  end

  // An entry is live when its distance from the head is below the fill count.
  always_comb begin
    o_matchVec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_rel[i] = PTR_W'(i) - r_head;
      if (({1'b0, w_rel[i]} < r_count) && (r_entries[i].pc == i_snoopAddr))
        o_matchVec[i] = 1'b1;
    end
  end

  assign w_nextHead   = r_head + PTR_W'(1);
  assign o_survivorPc = i_pop ? r_entries[w_nextHead].pc : r_entries[r_head].pc;

  assign o_full     = (r_count == CNT_W'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_headPc   = o_empty ? '0 : r_entries[r_head].pc;
  assign o_headWord = o_empty ? '0 : r_entries[r_head].word;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the program counter and mainRAM read port 1, prefetches into
// instr_queue and hands instructions to decode; handles redirects and store snoops.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int addWidth = 8,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fetchEn,
  output logic [addWidth-1:0] memAddr,
  input  logic [INSTR_W-1:0]  memData,
  input  logic                snoopWe,
  input  logic [addWidth-1:0] snoopAddr,
  input  logic                redirect,
  input  logic [addWidth-1:0] redirectPC,
  output logic                instrValid,
  input  logic                instrReady,
  output logic [INSTR_W-1:0]  instr,
  output logic [addWidth-1:0] instrPC
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [addWidth-1:0] r_fetchPC;
  logic                w_full;
  logic                w_empty;
  logic [CNT_W-1:0]    w_count;
  logic [DEPTH-1:0]    w_matchVec;
  logic [addWidth-1:0] w_survivorPc;
  logic                w_survivorValid;
  logic                w_pop;
  logic                w_snoopHit;
  logic                w_staleRead;
  logic                w_push;
  logic                w_flush;

  assign w_pop       = instrValid && instrReady;
  assign w_snoopHit  = snoopWe && (|w_matchVec);
  // The RAM returns the pre-write word when a store lands on the address being read.
  assign w_staleRead = snoopWe && (snoopAddr == r_fetchPC);
  assign w_push      = fetchEn && (!w_full || w_pop) && !redirect && !w_snoopHit && !w_staleRead;
  assign w_flush     = redirect || w_snoopHit;

  assign w_survivorValid = w_pop ? (w_count > CNT_W'(1)) : !w_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetchPC <= addWidth'(RESET_PC);
    end else if (redirect) begin
      r_fetchPC <= redirectPC;
    end else if (w_snoopHit) begin
      if (w_survivorValid) r_fetchPC <= w_survivorPc;
    end else if (w_push) begin
      r_fetchPC <= r_fetchPC + addWidth'(1);
    end
  end

  instr_queue #(
    .addWidth (addWidth),
    .DEPTH    (DEPTH)
  ) u_queue (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_pop        (w_pop),
    .i_flush      (w_flush),
    .i_pushPc     (r_fetchPC),
    .i_pushWord   (memData),
    .i_snoopAddr  (snoopAddr),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_count      (w_count),
    .o_headPc     (instrPC),
    .o_headWord   (instr),
    .o_matchVec   (w_matchVec),
    .o_survivorPc (w_survivorPc)
  );

  assign memAddr    = r_fetchPC;
  assign instrValid = !w_empty;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage directly upstream of decode, and the sole driver of mainRAM read port 1. Holds the program counter and drives the RAM read address. Captures the combinationally returned word into a small prefetch queue and presents instructions to decode with a valid/ready handshake. Also handles branch redirects and flushes stale prefetches when the store path writes an address already fetched.

## Interface
- addWidth, 8: word-address width; must match mainRAM addWidth
- DEPTH, 4: prefetch queue entries; power of two, at least 2
- RESET_PC, 0: fetch address after reset
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- fetchEn  in  1  1 = fetch allowed; 0 = hold PC, queue keeps draining
- memAddr  out  addWidth  read address to mainRAM RSelect1; equals fetchPC combinationally
- memData  in  32  mainRAM readDB1; valid in the same cycle as memAddr
- snoopWe  in  1  mainRAM wEnable
- snoopAddr  in  addWidth  mainRAM WSelect
- redirect  in  1  branch taken or jump, one-cycle pulse
- redirectPC  in  addWidth  new fetch address
- instrValid  out  1  queue head is valid
- instrReady  in  1  decode accepts the head
- instr  out  32  head instruction word; 0 when empty
- instrPC  out  addWidth  head instruction address; 0 when empty

## Operation
- State: fetchPC, queue of {pc, word} entries, head/tail pointers of log2(DEPTH) bits, count of log2(DEPTH)+1 bits.
- Pop: occurs when instrValid && instrReady; the head pointer advances.
- Push condition, all required:
  - fetchEn = 1;
  - (count < DEPTH) or a pop occurs in the same cycle;
  - no redirect;
  - no snoop hit;
  - not (snoopWe && snoopAddr == fetchPC).
- Push action: write {fetchPC, memData} at the tail, then fetchPC <= fetchPC + 1, modulo 2^addWidth. The wrap from all-ones to 0 is legal.
- Stale same-cycle read: when snoopWe && snoopAddr == fetchPC, the RAM returns the pre-write word. Skip the push and keep fetchPC; the next cycle refetches the new data.
- Snoop hit: snoopWe, and snoopAddr equals the pc of any valid queue entry.
  - Flush the queue: count = 0, pointers reset.
  - fetchPC <= the pc of the oldest valid entry. If a pop happens in the same cycle, use the next-oldest entry instead. If that popped head was the only entry, fetchPC is unchanged.
- Redirect: flush the queue, fetchPC <= redirectPC, no push.
  - A pop in the redirect cycle still counts as transferred; decode is responsible for discarding it.
- Priority: rst > redirect > snoop hit > push/pop.
- fetchEn = 0 never flushes the queue; pops continue normally.

## Timing
- Reset values: fetchPC = RESET_PC, count = 0, instrValid = 0, instr = 0, instrPC = 0. memAddr = RESET_PC during and after reset.
- Fetch latency: a push at edge N gives instrValid = 1 from cycle N+1.
- Redirect latency:
  - redirect sampled at edge N;
  - memAddr = redirectPC in cycle N+1;
  - instrValid with instrPC = redirectPC in cycle N+2.
- Throughput: with instrReady held high, one instruction per cycle indefinitely. Push and pop in the same cycle leave count unchanged.
- Full: count = DEPTH and no pop, so no push; fetchPC holds and memAddr is stable.
- Empty: instrValid = 0; instrReady is ignored.
- Outputs are combinational from the queue head. instrValid never depends combinationally on instrReady.
- Reset mid-operation: all queued entries are discarded at the reset edge, with no partial handshake.

## Structure
- Shared package:
  - INSTR_W = 32;
  - default RESET_PC;
  - fetch entry struct {pc, word}, parameterised through addWidth at the use site.
- Sub-module instr_queue: a synchronous FIFO with push, pop, flush, full, empty and count outputs. It also provides a per-entry pc match vector for snooping and an oldest-surviving-pc output.
- The top level holds fetchPC, the priority logic and the memAddr drive.

## Test plan
- Reset then fetchEn = 1, instrReady = 1, RAM words 0..7 = 0x11..0x18 → from cycle 1, one instr per cycle: pc 0 → 0x11, pc 1 → 0x12, … with no gaps.
- instrReady = 0 for 10 cycles → queue fills to DEPTH = 4 and memAddr holds at 4. Release → pcs 0..3 then 4 drain in order with no duplicate or skip.
- Redirect to 0x40 while the queue holds pcs 5..8 → pcs 5..8 never appear after the redirect cycle. memAddr = 0x40 one cycle later; instrPC = 0x40 two cycles later.
- Store (snoopWe) to pc 6 while the queue holds 5..8, no pop → queue flushed, fetchPC = 5, and the refetched pc 6 word is the newly written value.
- snoopWe with snoopAddr = fetchPC = 9, data 0xDEAD → no push that cycle; the next cycle pushes pc 9 with word 0xDEAD.
- redirectPC = 0xFE with addWidth = 8 → instrPC sequence 0xFE, 0xFF, 0x00, 0x01. Assert rst mid-stream → instrValid = 0 the next cycle and memAddr = RESET_PC.
